cpu_trace_buf: RTL
==================

Name: cpu_trace_buf

Overview:
- Parametrised capture buffer for the CPU's retired-instruction stream (instruction code, ALU result, ZF/OF).
- Sits beside the CPU core in the board top and replaces the fixed flag/result-to-LED path.
- Keeps the last DEPTH samples in a circular buffer; an index plus SW select one LED_W-bit slice of any stored sample.
- Optional trigger freezes the history a set number of samples after a matching ALU result.

Parameters:
- DATA_W, 32, width of instruction code and ALU result.
- DEPTH, 16, number of trace entries; power of two, at least 2; AW = log2(DEPTH).
- LED_W, 8, display slice width; must divide DATA_W.
- SEL_W, 3, SW width; top bit selects the field, lower bits select the slice.
- POST_N, 8, samples captured after the trigger sample before halting; range 0..DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous buffer clear; same effect as rst, lower priority.
- cap_valid  in  1  sample strobe, one sample per cycle while high.
- inst_code  in  DATA_W  instruction code of the sample.
- alu_f  in  DATA_W  ALU result of the sample.
- zf  in  1  zero flag of the sample.
- of  in  1  overflow flag of the sample.
- freeze  in  1  level; while high, samples are dropped.
- rd_idx  in  AW  age index; 0 = newest entry.
- SW  in  SEL_W  field/slice select.
- trig_en  in  1  arms the trigger compare.
- trig_val  in  DATA_W  trigger compare value for alu_f.
- LED  out  LED_W  selected slice, registered.
- rd_flags  out  2  {zf,of} of the selected entry, registered.
- count  out  AW+1  valid entries, saturates at DEPTH.
- state  out  2  capture state: 0 RUN, 1 POST, 2 HALT.

Behaviour:
- Reset: wp=0, count=0, state=RUN, post_cnt=0, LED=0, rd_flags=0. Memory contents are don't-care.
- clr gives the same result as rst; rst has priority. A cap_valid in the clr cycle is dropped.
- Capture when cap_valid & !freeze & state!=HALT:
  - mem[wp] <= {zf,of,inst_code,alu_f}; wp <= wp+1 mod DEPTH (wraps DEPTH-1 -> 0).
  - count <= min(count+1, DEPTH).
  - When count==DEPTH the oldest entry is overwritten.
- Read address = (wp-1-rd_idx) mod DEPTH, computed on current wp, rd_idx and SW.
- Read latency: 1 cycle; LED and rd_flags register the read.
- Same-cycle write and read: the read sees pre-write contents and pre-write wp.
- Out of range: rd_idx >= count gives LED=0 and rd_flags=0. With count==0 all reads give 0.
- Slice select:
  - s = SW[SEL_W-2:0]; field = inst_code if SW[SEL_W-1]=0, else alu_f.
  - LED = field[s*LED_W +: LED_W].
  - A slice starting at or beyond DATA_W yields 0.
- FSM, only active with the macro (see Optional Feature):
  - RUN -> POST on a captured sample with trig_en & alu_f==trig_val. The trigger sample is stored; post_cnt <= POST_N.
  - If POST_N==0, RUN -> HALT directly.
  - POST: each captured sample decrements post_cnt. The capture that brings post_cnt to 0 moves the FSM to HALT.
  - While in POST, a match does not re-trigger.
  - HALT: no captures; reads continue. Exits only via rst or clr.
  - freeze pauses capture and post_cnt decrements in RUN and POST.

Optional Feature:
- Macro CPU_TRACE_TRIG_EN.
- Defined: trigger FSM as described above.
- Undefined: state is held at RUN (reads 0). trig_en and trig_val are ignored, no compare logic is built, and the buffer runs continuously.

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - state encodings TRC_RUN=2'd0, TRC_POST=2'd1, TRC_HALT=2'd2;
  - FLD_INST=1'b0, FLD_ALU=1'b1;
  - the entry-width function (2+2*DATA_W).
- One sub-module: trace_ram, a DEPTH x (2+2*DATA_W) simple dual-port memory with synchronous write and registered read. Slice mux and FSM stay in cpu_trace_buf.

Test Plan:
- Reset/empty: rst high for 2 cycles, then idle -> count=0, state=0, LED=0 for every rd_idx/SW.
- Fill and read: 5 samples with inst_code=0x11223344+k and alu_f=k (k=0..4); rd_idx=0, SW=3'b000 -> LED=0x48 one cycle later. SW=3'b011 -> 0x11. SW=3'b100 -> 0x04. rd_idx=4, SW=3'b100 -> 0x00 (entry k=0). rd_idx=5 -> 0 (out of range).
- Wrap: 20 samples with alu_f=k (k=0..19) -> count=16. rd_idx=15, SW=3'b100 -> LED=0x04 (oldest entry, k=4). rd_idx=0 -> 0x13.
- Freeze/clr: freeze high across 3 strobes -> count unchanged. clr together with cap_valid -> count=0 and the sample is dropped.
- Trigger (macro on, POST_N=8): trig_en=1, trig_val=0x7. Stream alu_f=k (k=0..29) -> state=1 after k=7 is captured, state=2 after k=15. rd_idx=0 -> LED=0x0F (SW=3'b100). The state does not change as later samples arrive.
- Trigger (macro off): same stimulus -> state stays 0. rd_idx=0 -> LED=0x1D, count=16.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug blocks: capture-state encoding,
// trace field selectors and the packed trace-entry width.
package cpu_dbg_pkg;

   typedef enum logic [1:0] {
      TRC_RUN  = 2'd0,
      TRC_POST = 2'd1,
      TRC_HALT = 2'd2
   } trc_state_e;

   localparam logic FLD_INST = 1'b0;
   localparam logic FLD_ALU  = 1'b1;

   // Entry layout, MSB first: {zf, of, inst_code, alu_f}
   function automatic int entry_w(input int data_w);
      return 2 + 2 * data_w;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace memory: synchronous write, registered read.
// A read of the address being written returns the old contents.
module trace_ram #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 66,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset so it maps onto RAM macros; entries are only
   // ever observed after being written, because the reader gates on count.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/cpu_trace_buf.sv
// Circular capture buffer for the retired-instruction stream with an LED
// slice readout. Define CPU_TRACE_TRIG_EN to build the post-trigger freeze FSM.
module cpu_trace_buf
   import cpu_dbg_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 16,
   parameter  int LED_W  = 8,
   parameter  int SEL_W  = 3,
   parameter  int POST_N = 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              cap_valid,
   input  logic [DATA_W-1:0] inst_code,
   input  logic [DATA_W-1:0] alu_f,
   input  logic              zf,
   input  logic              of,
   input  logic              freeze,
   input  logic [AW-1:0]     rd_idx,
   input  logic [SEL_W-1:0]  SW,
   input  logic              trig_en,
   input  logic [DATA_W-1:0] trig_val,
   output logic [LED_W-1:0]  LED,
   output logic [1:0]        rd_flags,
   output logic [AW:0]       count,
   output logic [1:0]        state
);

   localparam int            EW     = entry_w(DATA_W);
   localparam int            NSLICE = DATA_W / LED_W;
   localparam logic [AW-1:0] ONE    = 1;
   localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);

   trc_state_e        state_q;
   logic [AW-1:0]     wp;
   logic [AW-1:0]     raddr;
   logic [EW-1:0]     rdata;
   logic              cap;
   logic              rd_ok, rd_ok_q;
   logic [SEL_W-1:0]  sw_q;
   logic [DATA_W-1:0] field;
   logic [LED_W-1:0]  led_c;

   assign cap   = cap_valid && !freeze && (state_q != TRC_HALT) && !clr && !rst;
   assign raddr = wp - ONE - rd_idx;
   assign rd_ok = {1'b0, rd_idx} < count;

   trace_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
      .clk   (clk),
      .we    (cap),
      .waddr (wp),
      .wdata ({zf, of, inst_code, alu_f}),
      .raddr (raddr),
      .rdata (rdata)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wp      <= '0;
         count   <= '0;
         rd_ok_q <= 1'b0;
         sw_q    <= '0;
      end else begin
         if (cap) begin
            wp <= wp + ONE;
            if (count != FULL) count <= count + 1'b1;
         end
         rd_ok_q <= rd_ok;
         sw_q    <= SW;
      end
   end

   // Slice select runs on the registered RAM word and registered SW, so LED
   // still changes only on a clock edge.
   always_comb begin
      // NOTE: defaults first so no path through this block can infer a latch.
      led_c = '0;
      field = (sw_q[SEL_W-1] == FLD_ALU) ? rdata[DATA_W-1:0] : rdata[2*DATA_W-1:DATA_W];
      for (int i = 0; i < NSLICE; i++) begin
         if (int'(sw_q[SEL_W-2:0]) == i) led_c = field[i*LED_W +: LED_W];
      end
   end

   assign LED      = rd_ok_q ? led_c : '0;
   assign rd_flags = rd_ok_q ? rdata[EW-1 -: 2] : 2'b00;
   assign state    = state_q;

`ifdef CPU_TRACE_TRIG_EN
   trc_state_e    state_d;
   logic [AW-1:0] post_q, post_d;
   logic          hit;

   assign hit = trig_en && (alu_f == trig_val);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q <= TRC_RUN;
         post_q  <= '0;
      end else begin
         state_q <= state_d;
         post_q  <= post_d;
      end
   end

   always_comb begin
      state_d = state_q;
      post_d  = post_q;
      unique case (state_q)
         TRC_RUN: begin
            if (cap && hit) begin
               if (POST_N == 0) begin
                  state_d = TRC_HALT;
               end else begin
                  state_d = TRC_POST;
                  post_d  = AW'(POST_N);
               end
            end
         end
         TRC_POST: begin
            if (cap) begin
               post_d = post_q - ONE;
               if (post_q == ONE) state_d = TRC_HALT;
            end
         end
         default: ;
      endcase
   end
`else
   logic unused_trig;

   assign state_q     = TRC_RUN;
   assign unused_trig = ^{trig_en, trig_val};
`endif

endmodule
